// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive path: FSM encoding, frame byte
// offsets, protocol constants and default station settings.
package eth_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DST,
      ST_SRC,
      ST_ETYPE,
      ST_HDR,
      ST_CHK,
      ST_PAYLOAD,
      ST_DROP
   } state_t;

   localparam int DST_OFS   = 0;
   localparam int SRC_OFS   = 6;
   localparam int ETYPE_OFS = 12;
   localparam int HDR_OFS   = 14;
   localparam int HDR_LEN   = 20;

   localparam logic [15:0] ETHERTYPE_IP = 16'h0800;
   localparam logic [47:0] BCAST_MAC    = 48'hFF_FF_FF_FF_FF_FF;

   localparam int          ADDR_W          = 11;
   localparam logic [47:0] DEF_MY_MAC      = 48'h02_00_00_00_00_01;
   localparam int          DEF_MAX_PAYLOAD = 1480;
   localparam int          DEF_CHK_DLY     = 2;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/eth_rx_ip_sequencer_if.sv
// Byte stream, checker handshake, payload RAM write port and status of the
// receive sequencer, bundled for connection to its environment.
interface eth_rx_ip_sequencer_if;
   import eth_pkg::*;

   logic              rx_dv;
   logic [7:0]        rx_data;
   logic              is_ip;
   logic [7:0]        ip_data;
   logic              ip_bad;
   logic              pl_we;
   logic [ADDR_W-1:0] pl_addr;
   logic              frame_done;
   logic [ADDR_W:0]   frame_len;
   logic              frame_drop;
   logic [15:0]       ok_cnt;
   logic [15:0]       drop_cnt;

   modport master (
      input  rx_dv, rx_data, ip_bad,
      output is_ip, ip_data, pl_we, pl_addr, frame_done, frame_len,
             frame_drop, ok_cnt, drop_cnt
   );

   modport slave (
      output rx_dv, rx_data, ip_bad,
      input  is_ip, ip_data, pl_we, pl_addr, frame_done, frame_len,
             frame_drop, ok_cnt, drop_cnt
   );
endinterface

// File: rtl/eth_mac_filter.sv
// Serial destination-MAC comparator: accumulates per-byte matches so that
// match_me / match_bcast are valid while byte 5 is presented.
module eth_mac_filter
   import eth_pkg::*;
#(
   parameter logic [47:0] MY_MAC = DEF_MY_MAC
) (
   input  logic       clock,
   input  logic       sclr,
   input  logic       en,
   input  logic       first,
   input  logic [2:0] idx,
   input  logic [7:0] data,
   output logic       match_me,
   output logic       match_bcast
);
   logic [7:0] me_byte [8];
   logic [7:0] bc_byte [8];
   logic       me_ok_reg;
   logic       bc_ok_reg;

   // Entries 6..7 only pad the 3-bit index range; they are never selected.
   for (genvar gi = 0; gi < 8; gi++) begin : g_byte
      if (gi < 6) begin : g_mac
         assign me_byte[gi] = MY_MAC[47 - 8*gi -: 8];
         assign bc_byte[gi] = BCAST_MAC[47 - 8*gi -: 8];
      end else begin : g_pad
         assign me_byte[gi] = 8'h00;
         assign bc_byte[gi] = 8'h00;
      end
   end

   assign match_me    = (first || me_ok_reg) && (data == me_byte[idx]);
   assign match_bcast = (first || bc_ok_reg) && (data == bc_byte[idx]);

   always_ff @(posedge clock) begin
      if (sclr) begin
         me_ok_reg <= 1'b0;
         bc_ok_reg <= 1'b0;
      end else if (en) begin
         me_ok_reg <= match_me;
         bc_ok_reg <= match_bcast;
      end
   end
endmodule

// File: rtl/eth_rx_ip_sequencer.sv
// Receive frame sequencer: filters on MAC/EtherType, frames the IP header for
// the checker, then writes the payload to RAM or drops the frame.
module eth_rx_ip_sequencer
   import eth_pkg::*;
#(
   parameter logic [47:0] MY_MAC      = DEF_MY_MAC,
   parameter int          MAX_PAYLOAD = DEF_MAX_PAYLOAD,
   parameter int          CHK_DLY     = DEF_CHK_DLY
) (
   input logic                   clock,
   input logic                   sclr,
   eth_rx_ip_sequencer_if.master bus
);
   localparam logic [7:0]      DST_LAST   = 8'(SRC_OFS - 1);
   localparam logic [7:0]      SRC_LAST   = 8'(ETYPE_OFS - 1);
   localparam logic [7:0]      ETYPE_LAST = 8'(HDR_OFS - 1);
   localparam logic [7:0]      HDR_LAST   = 8'(HDR_OFS + HDR_LEN - 1);
   localparam logic [7:0]      CHK_IDX    = 8'(HDR_OFS + HDR_LEN + CHK_DLY);
   localparam logic [ADDR_W:0] MAX_PL     = (ADDR_W+1)'(MAX_PAYLOAD);

   state_t            state_reg;
   logic              rx_dv_d_reg;
   logic [7:0]        idx_reg;
   logic [7:0]        etype_hi_reg;
   logic [ADDR_W:0]   wr_cnt_reg;
   logic [7:0]        ip_data_reg;
   logic              is_ip_reg;
   logic              pl_we_reg;
   logic [ADDR_W-1:0] pl_addr_reg;
   logic              frame_done_reg;
   logic [ADDR_W:0]   frame_len_reg;
   logic              frame_drop_reg;
   logic [15:0]       ok_cnt_reg;
   logic [15:0]       drop_cnt_reg;

   logic       frame_start, runt, wr_full, chk_sample;
   logic       filt_en, match_me, match_bcast;
   logic [2:0] filt_idx;

   assign frame_start = bus.rx_dv && !rx_dv_d_reg;
   assign runt        = !bus.rx_dv &&
                        (state_reg inside {ST_DST, ST_SRC, ST_ETYPE, ST_HDR});
   assign wr_full     = (wr_cnt_reg == MAX_PL);
   assign chk_sample  = (idx_reg == CHK_IDX);
   assign filt_en     = (state_reg == ST_IDLE && frame_start) || state_reg == ST_DST;
   assign filt_idx    = (state_reg == ST_IDLE) ? 3'd0 : idx_reg[2:0];

   eth_mac_filter #(.MY_MAC(MY_MAC)) u_filter (
      .clock       (clock),
      .sclr        (sclr),
      .en          (filt_en),
      .first       (frame_start),
      .idx         (filt_idx),
      .data        (bus.rx_data),
      .match_me    (match_me),
      .match_bcast (match_bcast)
   );

   always_ff @(posedge clock) begin
      if (sclr) begin
         state_reg      <= ST_IDLE;
         rx_dv_d_reg    <= 1'b1;
         idx_reg        <= '0;
         etype_hi_reg   <= '0;
         wr_cnt_reg     <= '0;
         ip_data_reg    <= '0;
         is_ip_reg      <= 1'b0;
         pl_we_reg      <= 1'b0;
         pl_addr_reg    <= '0;
         frame_done_reg <= 1'b0;
         frame_len_reg  <= '0;
         frame_drop_reg <= 1'b0;
         ok_cnt_reg     <= '0;
         drop_cnt_reg   <= '0;
      end else begin
         rx_dv_d_reg    <= bus.rx_dv;
         ip_data_reg    <= bus.rx_data;
         pl_we_reg      <= 1'b0;
         frame_done_reg <= 1'b0;
         frame_drop_reg <= 1'b0;
         if (runt) begin
            state_reg      <= ST_IDLE;
            is_ip_reg      <= 1'b0;
            frame_drop_reg <= 1'b1;
            drop_cnt_reg   <= sat_inc(drop_cnt_reg);
         end else begin
            unique case (state_reg)
               ST_IDLE: if (frame_start) begin
                  state_reg  <= ST_DST;
                  idx_reg    <= 8'd1;
                  wr_cnt_reg <= '0;
               end
               ST_DST: begin
                  idx_reg <= idx_reg + 8'd1;
                  if (idx_reg == DST_LAST)
                     state_reg <= (match_me || match_bcast) ? ST_SRC : ST_DROP;
               end
               ST_SRC: begin
                  idx_reg <= idx_reg + 8'd1;
                  if (idx_reg == SRC_LAST) state_reg <= ST_ETYPE;
               end
               ST_ETYPE: begin
                  idx_reg      <= idx_reg + 8'd1;
                  etype_hi_reg <= bus.rx_data;
                  if (idx_reg == ETYPE_LAST)
                     state_reg <= ({etype_hi_reg, bus.rx_data} == ETHERTYPE_IP) ? ST_HDR : ST_DROP;
               end
               ST_HDR: begin
                  idx_reg   <= idx_reg + 8'd1;
                  is_ip_reg <= 1'b1;
                  if (idx_reg == HDR_LAST) state_reg <= ST_CHK;
               end
               // Bytes streaming in while the checker settles are payload already.
               ST_CHK: begin
                  if (chk_sample && bus.ip_bad) begin
                     is_ip_reg <= 1'b0;
                     if (bus.rx_dv) begin
                        state_reg <= ST_DROP;
                     end else begin
                        state_reg      <= ST_IDLE;
                        frame_drop_reg <= 1'b1;
                        drop_cnt_reg   <= sat_inc(drop_cnt_reg);
                     end
                  end else if (!bus.rx_dv) begin
                     state_reg      <= ST_IDLE;
                     is_ip_reg      <= 1'b0;
                     frame_done_reg <= 1'b1;
                     frame_len_reg  <= wr_cnt_reg;
                     ok_cnt_reg     <= sat_inc(ok_cnt_reg);
                  end else if (wr_full) begin
                     state_reg <= ST_DROP;
                     is_ip_reg <= 1'b0;
                  end else begin
                     pl_we_reg   <= 1'b1;
                     pl_addr_reg <= wr_cnt_reg[ADDR_W-1:0];
                     wr_cnt_reg  <= wr_cnt_reg + 1'b1;
                     idx_reg     <= idx_reg + 8'd1;
                     if (chk_sample) state_reg <= ST_PAYLOAD;
                  end
               end
               ST_PAYLOAD: begin
                  if (!bus.rx_dv) begin
                     state_reg      <= ST_IDLE;
                     is_ip_reg      <= 1'b0;
                     frame_done_reg <= 1'b1;
                     frame_len_reg  <= wr_cnt_reg;
                     ok_cnt_reg     <= sat_inc(ok_cnt_reg);
                  end else if (wr_full) begin
                     state_reg <= ST_DROP;
                     is_ip_reg <= 1'b0;
                  end else begin
                     pl_we_reg   <= 1'b1;
                     pl_addr_reg <= wr_cnt_reg[ADDR_W-1:0];
                     wr_cnt_reg  <= wr_cnt_reg + 1'b1;
                  end
               end
               ST_DROP: begin
                  is_ip_reg <= 1'b0;
                  if (!bus.rx_dv) begin
                     state_reg      <= ST_IDLE;
                     frame_drop_reg <= 1'b1;
                     drop_cnt_reg   <= sat_inc(drop_cnt_reg);
                  end
               end
            endcase
         end
      end
   end

   assign bus.is_ip      = is_ip_reg;
   assign bus.ip_data    = ip_data_reg;
   assign bus.pl_we      = pl_we_reg;
   assign bus.pl_addr    = pl_addr_reg;
   assign bus.frame_done = frame_done_reg;
   assign bus.frame_len  = frame_len_reg;
   assign bus.frame_drop = frame_drop_reg;
   assign bus.ok_cnt     = ok_cnt_reg;
   assign bus.drop_cnt   = drop_cnt_reg;
endmodule

// File: tb/tb_eth_rx_ip_sequencer.sv
// Directed bench for eth_rx_ip_sequencer: a table of whole frames with expected
// outcomes, plus back-to-back and mid-frame reset sequences.
module tb_eth_rx_ip_sequencer;
   localparam logic [47:0] MY    = 48'h02_00_00_00_00_01;
   localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
   localparam logic [47:0] BC    = 48'hFF_FF_FF_FF_FF_FF;

   typedef struct {
      logic [47:0] dst;
      logic [15:0] etype;
      int          pay_len;
      int          cut;       // total bytes sent if >= 0, else full frame
      bit          bad;
      int          exp_done;
      int          exp_drop;
      int          exp_we;
      int          exp_isip;
   } vec_t;

   logic clock;
   logic sclr;

   eth_rx_ip_sequencer_if bus_if ();

   eth_rx_ip_sequencer dut (
      .clock (clock),
      .sclr  (sclr),
      .bus   (bus_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_vec = 0;
   int miscompares = 0;
   int tot_we = 0, tot_done = 0, tot_drop = 0, tot_isip = 0, tot_err = 0;
   int b_we, b_done, b_drop, b_isip, b_err;
   int exp_ok = 0, exp_drp = 0, exp_len = 0;
   vec_t vecs [13];

   function automatic logic [7:0] pat(input int i);
      return 8'((i * 7 + 3) & 255);
   endfunction

   function automatic logic [7:0] frame_byte(input logic [47:0] dst,
                                             input logic [15:0] et, input int s);
      logic [47:0] src;
      src = 48'h02_00_00_00_00_99;
      if (s < 6)   return dst[47 - 8*s -: 8];
      if (s < 12)  return src[47 - 8*(s-6) -: 8];
      if (s == 12) return et[15:8];
      if (s == 13) return et[7:0];
      if (s == 14) return 8'h45;
      if (s < 34)  return 8'((s - 14) * 3);
      return pat(s - 34);
   endfunction

   // Output monitor: sampled 1 time unit after each rising edge.
   initial begin
      int  we_idx;
      bit  isip_prev;
      we_idx = 0;
      isip_prev = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         if (bus_if.pl_we) begin
            tot_we++;
            if (!bus_if.is_ip || int'(bus_if.pl_addr) != we_idx || bus_if.ip_data != pat(we_idx))
               tot_err++;
            we_idx++;
         end
         if (!bus_if.is_ip) we_idx = 0;
         if (bus_if.is_ip) tot_isip++;
         if (bus_if.is_ip && !isip_prev && bus_if.ip_data != 8'h45) tot_err++;
         isip_prev = bus_if.is_ip;
         if (bus_if.frame_done) tot_done++;
         if (bus_if.frame_drop) tot_drop++;
         if (bus_if.frame_done && bus_if.frame_drop) tot_err++;
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic snap();
      b_we = tot_we; b_done = tot_done; b_drop = tot_drop;
      b_isip = tot_isip; b_err = tot_err;
   endtask

   // Slots 0..n-1 carry bytes, the following gap slots are idle. ip_bad is
   // pulsed in the cycle the checker verdict is due (slot 36).
   task automatic send_frame(input logic [47:0] dst, input logic [15:0] et,
                             input int pay_len, input int cut, input bit bad,
                             input int gap, input int sclr_slot);
      int n;
      n = (cut >= 0) ? cut : 34 + pay_len;
      for (int s = 0; s < n + gap; s++) begin
         @(negedge clock);
         bus_if.rx_dv   = (s < n);
         bus_if.rx_data = (s < n) ? frame_byte(dst, et, s) : 8'h00;
         bus_if.ip_bad  = bad && (s == 36);
         sclr           = (s == sclr_slot);
      end
   endtask

   task automatic check_frame(input string tag, input int e_done, input int e_drop,
                              input int e_we, input int e_isip);
      check({tag, ".done"}, tot_done - b_done, e_done);
      check({tag, ".drop"}, tot_drop - b_drop, e_drop);
      check({tag, ".writes"}, tot_we - b_we, e_we);
      check({tag, ".is_ip_cycles"}, tot_isip - b_isip, e_isip);
      check({tag, ".addr_data_hdr_errs"}, tot_err - b_err, 0);
      exp_ok  += e_done;
      exp_drp += e_drop;
      if (e_done > 0) exp_len = e_we;
      check({tag, ".frame_len"}, bus_if.frame_len, exp_len);
      check({tag, ".ok_cnt"}, bus_if.ok_cnt, exp_ok);
      check({tag, ".drop_cnt"}, bus_if.drop_cnt, exp_drp);
      n_vec++;
   endtask

   initial begin
      //          dst    etype     pay   cut  bad  done drop we    isip
      vecs[0]  = '{MY,    16'h0800, 46,   -1,  1'b0, 1,  0,  46,   66};
      vecs[1]  = '{MY,    16'h0800, 46,   -1,  1'b1, 0,  1,  2,    22};
      vecs[2]  = '{OTHER, 16'h0800, 46,   -1,  1'b0, 0,  1,  0,    0};
      vecs[3]  = '{MY,    16'h0806, 46,   -1,  1'b0, 0,  1,  0,    0};
      vecs[4]  = '{BC,    16'h0800, 10,   -1,  1'b0, 1,  0,  10,   30};
      vecs[5]  = '{MY,    16'h0800, 0,    -1,  1'b0, 1,  0,  0,    20};
      vecs[6]  = '{MY,    16'h0800, 2,    -1,  1'b1, 0,  1,  2,    22};
      vecs[7]  = '{MY,    16'h0800, 2,    -1,  1'b0, 1,  0,  2,    22};
      vecs[8]  = '{MY,    16'h0800, 1,    -1,  1'b1, 1,  0,  1,    21};
      vecs[9]  = '{MY,    16'h0800, 1480, -1,  1'b0, 1,  0,  1480, 1500};
      vecs[10] = '{MY,    16'h0800, 1481, -1,  1'b0, 0,  1,  1480, 1500};
      vecs[11] = '{MY,    16'h0800, 46,   3,   1'b0, 0,  1,  0,    0};
      vecs[12] = '{MY,    16'h0800, 46,   13,  1'b0, 0,  1,  0,    0};

      sclr = 1'b1;
      bus_if.rx_dv = 1'b0;
      bus_if.rx_data = 8'h00;
      bus_if.ip_bad = 1'b0;
      repeat (3) @(negedge clock);
      check("reset.is_ip", bus_if.is_ip, 0);
      check("reset.ip_data", bus_if.ip_data, 0);
      check("reset.pl_we", bus_if.pl_we, 0);
      check("reset.pl_addr", bus_if.pl_addr, 0);
      check("reset.frame_done", bus_if.frame_done, 0);
      check("reset.frame_len", bus_if.frame_len, 0);
      check("reset.frame_drop", bus_if.frame_drop, 0);
      check("reset.ok_cnt", bus_if.ok_cnt, 0);
      check("reset.drop_cnt", bus_if.drop_cnt, 0);
      sclr = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 13; i++) begin
         snap();
         send_frame(vecs[i].dst, vecs[i].etype, vecs[i].pay_len, vecs[i].cut,
                    vecs[i].bad, 4, -1);
         check_frame($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_drop,
                     vecs[i].exp_we, vecs[i].exp_isip);
         $display("vec%0d: done=%0d drop=%0d len=%0d ok_cnt=%0d drop_cnt=%0d", i,
                  tot_done - b_done, tot_drop - b_drop, bus_if.frame_len,
                  bus_if.ok_cnt, bus_if.drop_cnt);
      end

      // Runt ending mid-header, then a broadcast frame after one idle cycle.
      snap();
      send_frame(MY, 16'h0800, 46, 20, 1'b0, 1, -1);
      send_frame(BC, 16'h0800, 10, -1, 1'b0, 4, -1);
      check_frame("b2b", 1, 1, 10, 36);
      $display("b2b: runt + broadcast, len=%0d ok_cnt=%0d drop_cnt=%0d",
               bus_if.frame_len, bus_if.ok_cnt, bus_if.drop_cnt);

      // Reset at payload byte 10 with rx_dv held high: the rest is ignored.
      snap();
      exp_ok = 0; exp_drp = 0; exp_len = 0;
      send_frame(MY, 16'h0800, 46, -1, 1'b0, 4, 44);
      check_frame("sclr_mid", 0, 0, 10, 30);
      $display("sclr_mid: writes=%0d ok_cnt=%0d drop_cnt=%0d",
               tot_we - b_we, bus_if.ok_cnt, bus_if.drop_cnt);

      snap();
      send_frame(MY, 16'h0800, 5, -1, 1'b0, 4, -1);
      check_frame("after_sclr", 1, 0, 5, 25);
      $display("after_sclr: len=%0d ok_cnt=%0d", bus_if.frame_len, bus_if.ok_cnt);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
      $finish;
   end
endmodule

// File: doc/eth_rx_ip_sequencer.md
Name: eth_rx_ip_sequencer

Overview:
Receive-side frame sequencer for the Ethernet/IP path. It walks each incoming Ethernet frame byte by byte, filters on destination MAC and EtherType, and drives the IP header checker by holding its enable high for exactly the IP header bytes. It then accepts or drops the frame from the checker's verdict and writes the IP payload into the receive payload RAM, publishing length and status. It sits between the MAC byte stream (preamble/SFD already stripped) and the payload RAM.

Parameters:
MY_MAC, 48'h02_00_00_00_00_01, station MAC address; broadcast FF:FF:FF:FF:FF:FF is also accepted
ETHERTYPE_IP, 16'h0800, EtherType routed to the IP path
MAX_PAYLOAD, 1480, maximum payload bytes accepted; more causes a drop
ADDR_W, 11, payload RAM address width
CHK_DLY, 2, cycles after the last header byte on ip_data until ip_bad is valid

Ports:
clock  in  1  system clock; all logic on posedge
sclr  in  1  synchronous active-high reset
rx_dv  in  1  frame envelope; high for contiguous bytes, one byte per cycle, no gaps
rx_data  in  8  frame byte, valid while rx_dv=1
is_ip  out  1  enable to the IP header checker
ip_data  out  8  rx_data delayed one cycle, to the checker and the RAM
ip_bad  in  1  checker verdict (header checksum failed)
pl_we  out  1  payload RAM write strobe
pl_addr  out  ADDR_W  payload RAM address, 0-based per frame
frame_done  out  1  1-cycle pulse: frame accepted
frame_len  out  ADDR_W+1  payload length, valid with frame_done, held until next frame_done
frame_drop  out  1  1-cycle pulse: frame discarded
ok_cnt  out  16  accepted frames, saturating
drop_cnt  out  16  dropped frames, saturating

Behaviour:
- Reset values: all outputs 0, state IDLE, rx_dv_d = 1. Because rx_dv_d resets to 1, a frame already in flight when sclr deasserts is ignored until rx_dv falls.
- Frame start is the rising edge of rx_dv (rx_dv=1, rx_dv_d=0). A byte index counter starts at 0 on that first byte.
- ip_data is registered rx_data, so it has 1-cycle latency. All downstream strobes refer to ip_data timing.
- States:
  - IDLE: on frame start, go to DST.
  - DST (bytes 0-5): compare with MY_MAC and broadcast. If neither matches, go to DROP at byte 5.
  - SRC (bytes 6-11): ignored.
  - ETYPE (bytes 12-13): if the value is not ETHERTYPE_IP, go to DROP.
  - HDR (bytes 14-33): is_ip=1 while those 20 bytes are on ip_data. is_ip stays high through the CHK_DLY window.
  - CHK: sample ip_bad CHK_DLY cycles after header byte 33 appears on ip_data. If ip_bad=1, go to DROP. Otherwise go to PAYLOAD. Bytes arriving during CHK are already payload and are written.
  - PAYLOAD: pl_we=1 for each payload byte on ip_data. pl_addr increments after each write. is_ip stays high until the frame ends.
  - DROP: pl_we=0 and is_ip=0. Wait for rx_dv=0, then pulse frame_drop and return to IDLE.
- End of frame in PAYLOAD or CHK: when rx_dv falls, pulse frame_done the next cycle, set frame_len = number of bytes written, and return to IDLE. is_ip=0 in the same cycle.
- Runt: if rx_dv falls in DST, SRC, ETYPE or HDR, pulse frame_drop and do not write.
- Payload overflow: on the write that would exceed MAX_PAYLOAD, suppress pl_we and go to DROP.
- Simultaneous events: if ip_bad=1 in the sample cycle and rx_dv falls in the same cycle, the frame is dropped. frame_done and frame_drop are never asserted together.
- CRC/FCS bytes are written as payload; stripping them is the MAC's responsibility.
- Counters saturate at 16'hFFFF and are cleared only by sclr.
- sclr mid-frame: immediate IDLE, all strobes 0, no done/drop pulse. Counters clear.
- Minimum gap between frames is 1 idle cycle. Back-to-back frames separated by one rx_dv=0 cycle must both be handled.

Decomposition:
- Shared eth_pkg: state encoding, byte offsets (DST_OFS=0, ETYPE_OFS=12, HDR_OFS=14, HDR_LEN=20), ETHERTYPE_IP, BCAST_MAC.
- One sub-module, eth_mac_filter: a 6-byte serial comparator giving match_me and match_bcast at byte 5.
- The FSM and counters stay in the top module.

Test Plan:
- Unicast to MY_MAC, EtherType 0800, valid header, 46-byte payload -> is_ip high from ip_data byte 14; 46 pl_we pulses at addr 0..45; frame_done with frame_len=46; ok_cnt=1.
- Same frame with a corrupted checksum (checker ip_bad=1) -> no pl_we after the CHK sample; frame_drop once after rx_dv falls; drop_cnt=1.
- Destination 02:00:00:00:00:02 -> frame_drop; is_ip never asserted; pl_we never asserted.
- EtherType 0806 -> frame_drop; is_ip=0 throughout.
- rx_dv falls at byte 20 (mid-header) -> frame_drop, no writes. Then a valid broadcast frame one idle cycle later -> frame_done with the correct length.
- sclr asserted at payload byte 10 while rx_dv stays high -> no pulses, no further writes until rx_dv falls and a new frame starts; ok_cnt=drop_cnt=0.
